// File: rtl/gb_hdma_controller.sv
// gb_hdma_controller
//   CGB VRAM DMA sequencer for registers FF51-FF55. Supports general-purpose
//   transfers, which run back to back with the CPU halted, and HBlank
//   transfers, which move one block per rising edge of hblank. Source bytes
//   are fetched through a req/ack port, and each byte is written into VRAM
//   with a one-cycle strobe.
//
// Ports
//   clock, rst          system clock; asynchronous active-high reset
//   addr_bus, data_in   CPU address and write data
//   we                  CPU write strobe, one cycle per write
//   data_out            CPU read data (FF55 status; 8'hFF everywhere else)
//   cgb                 CGB mode enable for the register file
//   hblank              PPU mode-0 level
//   src_addr, src_req   source fetch request toward the memory controller
//   src_ack, src_data   one-cycle acknowledge, with the byte in the same cycle
//   vram_addr/data/we   VRAM write port
//   cpu_halt            CPU stall while a block is moving
//   busy                transfer armed or running
module gb_hdma_controller #(
  parameter int BLOCK_BYTES = 16,
  parameter int VRAM_AW     = 13
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [15:0]        addr_bus,
  input  logic [7:0]         data_in,
  input  logic               we,
  output logic [7:0]         data_out,
  input  logic               cgb,
  input  logic               hblank,
  output logic [15:0]        src_addr,
  output logic               src_req,
  input  logic               src_ack,
  input  logic [7:0]         src_data,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_data,
  output logic               vram_we,
  output logic               cpu_halt,
  output logic               busy
);

  localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [VRAM_AW-1:0] DST_RST = {{(VRAM_AW-4){1'b1}}, 4'h0};

  typedef enum logic [2:0] {
    IDLE, WAIT_HB, RD, WAIT_ACK, WR, BLK_END
  } state_e;

  state_e             state_q;
  logic [15:0]        src_q;
  logic [VRAM_AW-1:0] dst_q;
  logic [6:0]         remaining_q;
  logic               mode_q;
  logic               cancel_q;     // cancel requested, honoured at the block boundary
  logic               cancelled_q;  // last transfer ended by cancel (drives FF55 bit 7)
  logic [CNT_W-1:0]   byte_cnt_q;
  logic               hblank_q;
  logic [15:0]        src_addr_q;
  logic               src_req_q;
  logic [VRAM_AW-1:0] vram_addr_q;
  logic [7:0]         vram_data_q;
  logic               vram_we_q;
  logic               cpu_halt_q;
  logic               busy_q;

  logic wr_en, wr_ff51, wr_ff52, wr_ff53, wr_ff54, wr_ff55;
  logic reg_wr_ok, hblank_rise_d, hb_active_d;

  assign wr_en   = we & cgb;
  assign wr_ff51 = wr_en && (addr_bus == 16'hFF51);
  assign wr_ff52 = wr_en && (addr_bus == 16'hFF52);
  assign wr_ff53 = wr_en && (addr_bus == 16'hFF53);
  assign wr_ff54 = wr_en && (addr_bus == 16'hFF54);
  assign wr_ff55 = wr_en && (addr_bus == 16'hFF55);

  // Address registers may only be changed while no block is moving.
  assign reg_wr_ok     = (state_q == IDLE) || (state_q == WAIT_HB);
  assign hblank_rise_d = hblank & ~hblank_q;
  assign hb_active_d   = mode_q && (state_q != IDLE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= 16'hFFF0;
      dst_q       <= DST_RST;
      remaining_q <= 7'h7F;
      mode_q      <= 1'b0;
      cancel_q    <= 1'b0;
      cancelled_q <= 1'b0;
      byte_cnt_q  <= '0;
      hblank_q    <= 1'b0;
      src_addr_q  <= 16'h0000;
      src_req_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= 8'h00;
      vram_we_q   <= 1'b0;
      cpu_halt_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      hblank_q <= hblank;

      if (reg_wr_ok) begin
        if (wr_ff51) src_q[15:8] <= data_in;
        if (wr_ff52) src_q[7:0]  <= {data_in[7:4], 4'h0};
        if (wr_ff53) dst_q[VRAM_AW-1:8] <= data_in[VRAM_AW-9:0];
        if (wr_ff54) dst_q[7:0]  <= {data_in[7:4], 4'h0};
      end

      // Bit 7 clear stops an HBlank transfer; bit 7 set while active is ignored.
      if (wr_ff55 && hb_active_d && !data_in[7]) cancel_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (wr_ff55) begin
            remaining_q <= data_in[6:0];
            mode_q      <= data_in[7];
            cancel_q    <= 1'b0;
            cancelled_q <= 1'b0;
            byte_cnt_q  <= '0;
            busy_q      <= 1'b1;
            if (data_in[7]) begin
              state_q <= WAIT_HB;
            end else begin
              state_q    <= RD;
              cpu_halt_q <= 1'b1;
            end
          end
        end
        WAIT_HB: begin
          // No block is in flight here, so a pending cancel ends at once.
          if (cancel_q) begin
            state_q     <= IDLE;
            cancel_q    <= 1'b0;
            cancelled_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (hblank_rise_d) begin
            state_q    <= RD;
            cpu_halt_q <= 1'b1;
          end
        end
        RD: begin
          src_addr_q <= src_q;
          src_req_q  <= 1'b1;
          state_q    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (src_ack) begin
            src_req_q   <= 1'b0;
            vram_data_q <= src_data;
            vram_addr_q <= dst_q;
            vram_we_q   <= 1'b1;
            state_q     <= WR;
          end
        end
        WR: begin
          vram_we_q <= 1'b0;
          src_q     <= src_q + 16'd1;
          dst_q     <= dst_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_q <= '0;
            state_q    <= BLK_END;
          end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            state_q    <= RD;
          end
        end
        BLK_END: begin
          if (cancel_q) begin
            state_q     <= IDLE;
            cancel_q    <= 1'b0;
            cancelled_q <= 1'b1;
            busy_q      <= 1'b0;
            cpu_halt_q  <= 1'b0;
          end else if (remaining_q == 7'd0) begin
            state_q     <= IDLE;
            remaining_q <= 7'h7F;
            busy_q      <= 1'b0;
            cpu_halt_q  <= 1'b0;
          end else begin
            remaining_q <= remaining_q - 7'd1;
            if (mode_q) begin
              state_q    <= WAIT_HB;
              cpu_halt_q <= 1'b0;
            end else begin
              state_q <= RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FF55 status: active -> {0,remaining}; after cancel -> {1,remaining}; else FF.
  always_comb begin
    data_out = 8'hFF;
    if (cgb && (addr_bus == 16'hFF55)) begin
      if (state_q != IDLE)  data_out = {1'b0, remaining_q};
      else if (cancelled_q) data_out = {1'b1, remaining_q};
    end
  end

  assign src_addr  = src_addr_q;
  assign src_req   = src_req_q;
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;
  assign vram_we   = vram_we_q;
  assign cpu_halt  = cpu_halt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gb_hdma_controller.sv
module tb_gb_hdma_controller;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in;
  logic        we;
  logic [7:0]  data_out;
  logic        cgb;
  logic        hblank;
  logic [15:0] src_addr;
  logic        src_req;
  logic        src_ack;
  logic [7:0]  src_data;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        cpu_halt;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;

  logic [12:0] wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          wr_n = 0;

  gb_hdma_controller #(.BLOCK_BYTES(16), .VRAM_AW(13)) dut (
    .clock(clock), .rst(rst), .addr_bus(addr_bus), .data_in(data_in), .we(we),
    .data_out(data_out), .cgb(cgb), .hblank(hblank), .src_addr(src_addr),
    .src_req(src_req), .src_ack(src_ack), .src_data(src_data),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we),
    .cpu_halt(cpu_halt), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory controller model: acks after ack_delay waiting cycles.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    src_ack  = 1'b0;
    src_data = 8'h00;
    forever begin
      @(negedge clock);
      if (rst) begin
        src_ack  = 1'b0;
        wait_cnt = 0;
      end else if (src_ack) begin
        src_ack = 1'b0;
      end else if (src_req) begin
        if (wait_cnt >= ack_delay) begin
          src_ack  = 1'b1;
          src_data = mem_byte(src_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (vram_we && wr_n < 256) begin
      wr_addr[wr_n] = vram_addr;
      wr_data[wr_n] = vram_data;
      wr_n = wr_n + 1;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    tick();
    addr_bus = a; data_in = d; we = 1'b1;
    tick();
    we = 1'b0; addr_bus = 16'h0000; data_in = 8'h00;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] v);
    addr_bus = a;
    #1;
    v = data_out;
    addr_bus = 16'h0000;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_halt(input logic lvl, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cpu_halt === lvl) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bit ok;
    int base;
    rst = 1'b1; cgb = 1'b1; hblank = 1'b0; we = 1'b0;
    addr_bus = 16'h0000; data_in = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests++; if (src_req !== 1'b0) begin fails++; $display("FAIL rst_src_req got %b want 0", src_req); end
    tests++; if (vram_we !== 1'b0) begin fails++; $display("FAIL rst_vram_we got %b want 0", vram_we); end
    tests++; if (cpu_halt !== 1'b0) begin fails++; $display("FAIL rst_cpu_halt got %b want 0", cpu_halt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (src_addr !== 16'h0000 || vram_addr !== 13'h0000 || vram_data !== 8'h00) begin
      fails++; $display("FAIL rst_addrs got src=%h vram=%h data=%h want 0", src_addr, vram_addr, vram_data); end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL rst_ff55 got %h want ff", v); end
    cpu_rd(16'hFF51, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL rst_ff51 got %h want ff", v); end
    // A transfer with untouched address registers uses the reset src/dst.
    base = wr_n;
    cpu_wr(16'hFF55, 8'h00);
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_default_timeout got busy=%b want 0", busy); end
    tests++; if (wr_n - base !== 16) begin fails++; $display("FAIL rst_default_count got %0d want 16", wr_n - base); end
    tests++; if (wr_addr[base] !== 13'h1FF0 || wr_data[base] !== mem_byte(16'hFFF0)) begin
      fails++; $display("FAIL rst_default_first got %h/%h want 1ff0/%h", wr_addr[base], wr_data[base], mem_byte(16'hFFF0)); end
    // cgb=0: status reads FF and writes do nothing.
    cgb = 1'b0;
    cpu_wr(16'hFF55, 8'h00);
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cgb_off_busy got %b want 0", busy); end
    cgb = 1'b1;
  endtask

  task automatic test_general();
    logic [7:0] v;
    int base, cyc, halt_gaps;
    base = wr_n;
    cpu_wr(16'hFF51, 8'hC0);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h01);
    cpu_wr(16'hFF54, 8'h00);
    cpu_wr(16'hFF55, 8'h00);
    cyc = 1; halt_gaps = (cpu_halt !== 1'b1) ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!busy) break;
      cyc++;
      if (cpu_halt !== 1'b1) halt_gaps++;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gen_timeout got busy=%b want 0", busy); end
    tests++; if (cyc !== 49) begin fails++; $display("FAIL gen_cycles got %0d want 49", cyc); end
    tests++; if (halt_gaps !== 0) begin fails++; $display("FAIL gen_halt_gaps got %0d want 0", halt_gaps); end
    tests++; if (cpu_halt !== 1'b0) begin fails++; $display("FAIL gen_halt_end got %b want 0", cpu_halt); end
    tests++; if (wr_n - base !== 16) begin fails++; $display("FAIL gen_count got %0d want 16", wr_n - base); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (wr_addr[base+i] !== 13'(13'h0100 + i) || wr_data[base+i] !== mem_byte(16'(16'hC000 + i))) begin
        fails++; $display("FAIL gen_byte%0d got %h/%h want %h/%h", i, wr_addr[base+i], wr_data[base+i],
                          13'(13'h0100 + i), mem_byte(16'(16'hC000 + i)));
      end
    end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL gen_ff55 got %h want ff", v); end
  endtask

  task automatic test_hblank();
    logic [7:0] v;
    logic [7:0] exp_ff55 [0:3];
    bit ok;
    int base;
    exp_ff55[0] = 8'h02; exp_ff55[1] = 8'h01; exp_ff55[2] = 8'h00; exp_ff55[3] = 8'hFF;
    base = wr_n;
    cpu_wr(16'hFF51, 8'hC1);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h02);
    cpu_wr(16'hFF54, 8'h00);
    cpu_wr(16'hFF55, 8'h83);
    repeat (20) tick();
    tests++; if (wr_n - base !== 0 || busy !== 1'b1 || cpu_halt !== 1'b0) begin
      fails++; $display("FAIL hb_armed got wr=%0d busy=%b halt=%b want 0/1/0", wr_n - base, busy, cpu_halt); end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'h03) begin fails++; $display("FAIL hb_ff55_armed got %h want 03", v); end
    for (int k = 0; k < 4; k++) begin
      hblank = 1'b1;
      tick();
      wait_halt(1'b1, 10, ok);
      if (ok) wait_halt(1'b0, 100, ok);
      tests++; if (!ok) begin fails++; $display("FAIL hb_block%0d_timeout got halt=%b want block done", k, cpu_halt); end
      cpu_rd(16'hFF55, v);
      tests++; if (v !== exp_ff55[k]) begin fails++; $display("FAIL hb_ff55_%0d got %h want %h", k, v, exp_ff55[k]); end
      tests++; if (wr_n - base !== 16*(k+1)) begin fails++; $display("FAIL hb_count_%0d got %0d want %0d", k, wr_n - base, 16*(k+1)); end
      hblank = 1'b0;
      repeat (3) tick();
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hb_busy_end got %b want 0", busy); end
    tests++; if (wr_addr[base+63] !== 13'h023F || wr_data[base+63] !== mem_byte(16'hC13F)) begin
      fails++; $display("FAIL hb_last_byte got %h/%h want 023f/%h", wr_addr[base+63], wr_data[base+63], mem_byte(16'hC13F)); end
  endtask

  task automatic test_cancel();
    logic [7:0] v;
    bit ok;
    int base;
    base = wr_n;
    cpu_wr(16'hFF51, 8'hD0);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h03);
    cpu_wr(16'hFF54, 8'h00);
    cpu_wr(16'hFF55, 8'h82);
    repeat (3) tick();
    hblank = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (wr_n - base >= 5) break;
      tick();
    end
    cpu_wr(16'hFF55, 8'h00);
    wait_idle(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL cancel_timeout got busy=%b want 0", busy); end
    tests++; if (wr_n - base !== 16) begin fails++; $display("FAIL cancel_count got %0d want 16", wr_n - base); end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'h82) begin fails++; $display("FAIL cancel_ff55 got %h want 82", v); end
    hblank = 1'b0;
    repeat (3) tick();
    hblank = 1'b1;
    repeat (60) tick();
    hblank = 1'b0;
    tests++; if (wr_n - base !== 16 || busy !== 1'b0) begin
      fails++; $display("FAIL cancel_after got wr=%0d busy=%b want 16/0", wr_n - base, busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    bit ok;
    int base;
    base = wr_n;
    cpu_wr(16'hFF51, 8'hFF);
    cpu_wr(16'hFF52, 8'hF0);
    cpu_wr(16'hFF53, 8'h1F);
    cpu_wr(16'hFF54, 8'hF0);
    cpu_wr(16'hFF55, 8'h01);
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_timeout got busy=%b want 0", busy); end
    tests++; if (wr_n - base !== 32) begin fails++; $display("FAIL wrap_count got %0d want 32", wr_n - base); end
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (wr_addr[base+i] !== 13'(13'h1FF0 + i) || wr_data[base+i] !== mem_byte(16'(16'hFFF0 + i))) begin
        fails++; $display("FAIL wrap_byte%0d got %h/%h want %h/%h", i, wr_addr[base+i], wr_data[base+i],
                          13'(13'h1FF0 + i), mem_byte(16'(16'hFFF0 + i)));
      end
    end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL wrap_ff55 got %h want ff", v); end
  endtask

  task automatic test_ack_delay_reset();
    logic [7:0] v;
    logic [15:0] addr0;
    int base, req_cnt, unstable;
    bit acked;
    base = wr_n;
    ack_delay = 5;
    cpu_wr(16'hFF51, 8'hC2);
    cpu_wr(16'hFF52, 8'h00);
    cpu_wr(16'hFF53, 8'h04);
    cpu_wr(16'hFF54, 8'h00);
    cpu_wr(16'hFF55, 8'h00);
    for (int i = 0; i < 10; i++) begin
      if (src_req) break;
      tick();
    end
    addr0 = src_addr; req_cnt = 0; unstable = 0; acked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (src_req) req_cnt++;
      if (src_addr !== addr0) unstable++;
      if (src_ack) begin acked = 1'b1; break; end
      tick();
    end
    tests++; if (!acked) begin fails++; $display("FAIL ack_timeout got no ack want ack"); end
    tests++; if (addr0 !== 16'hC200) begin fails++; $display("FAIL ack_addr got %h want c200", addr0); end
    tests++; if (req_cnt !== 6) begin fails++; $display("FAIL ack_req_cycles got %0d want 6", req_cnt); end
    tests++; if (unstable !== 0) begin fails++; $display("FAIL ack_addr_stable got %0d changes want 0", unstable); end
    repeat (3) tick();
    tests++; if (wr_n - base !== 1 || wr_data[base] !== mem_byte(16'hC200)) begin
      fails++; $display("FAIL ack_one_write got %0d/%h want 1/%h", wr_n - base, wr_data[base], mem_byte(16'hC200)); end
    tick();
    tests++; if (src_req !== 1'b1) begin fails++; $display("FAIL ack_second_req got %b want 1", src_req); end
    rst = 1'b1;
    #1;
    tests++; if (src_req !== 1'b0 || vram_we !== 1'b0 || cpu_halt !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_ctrl got req=%b we=%b halt=%b busy=%b want 0", src_req, vram_we, cpu_halt, busy); end
    tests++; if (src_addr !== 16'h0000 || vram_addr !== 13'h0000 || vram_data !== 8'h00) begin
      fails++; $display("FAIL midrst_data got %h/%h/%h want 0", src_addr, vram_addr, vram_data); end
    repeat (2) tick();
    rst = 1'b0;
    ack_delay = 0;
    repeat (10) tick();
    tests++; if (wr_n - base !== 1) begin fails++; $display("FAIL midrst_no_write got %0d want 1", wr_n - base); end
    cpu_rd(16'hFF55, v);
    tests++; if (v !== 8'hFF) begin fails++; $display("FAIL midrst_ff55 got %h want ff", v); end
  endtask

  initial begin
    test_reset();
    test_general();
    test_hblank();
    test_cancel();
    test_wrap();
    test_ack_delay_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
